// File: rtl/issue_unit_n_pkg.sv
// Shared types for the N-wide issue stage: queue element, FU packet, scoreboard entry sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package issue_unit_n_pkg;

  localparam int REG_WIDTH = 32;
  localparam int REG_ADDR  = 5;
  // accept_mask storage in the queue element; only the low STAGES bits are meaningful
  localparam int MASK_MAX  = 8;
  // scoreboard line field holds the issuing slot index (ISSUE_WIDTH <= 4)
  localparam int LINE_W    = 2;

  typedef enum logic [2:0] {
    EXE_NOP    = 3'd0,
    EXE_ALU    = 3'd1,
    EXE_MUL    = 3'd2,
    EXE_LSU    = 3'd3,
    EXE_BRUNCH = 3'd4
  } exe_type_t;

  // one issue-queue entry; need[j]==0 means operand j is the immediate
  typedef struct packed {
    exe_type_t                  exe_type;
    logic [7:0]                 opcode;
    logic [1:0]                 need;
    logic [1:0][REG_ADDR-1:0]   src_addr;
    logic [REG_WIDTH-1:0]       imm;
    logic                       write_reg_need;
    logic [REG_ADDR-1:0]        write_reg_addr;
    logic [MASK_MAX-1:0]        accept_mask;
  } iq_elem_t;

  // packet handed to the execute units
  typedef struct packed {
    exe_type_t                  exe_type;
    logic [7:0]                 opcode;
    logic [1:0][REG_WIDTH-1:0]  src_val;
    logic                       write_reg_need;
    logic [REG_ADDR-1:0]        write_reg_addr;
  } fu_req_t;

  localparam fu_req_t FU_NOP = '0;

  // scoreboard entry layout: {line, accept_mask[STAGES], position[STAGES]}
  function automatic int sb_entry_n(input int stages);
    return 2 * stages + LINE_W;
  endfunction

endpackage

// File: rtl/issue_unit_n_score_board.sv
// Shifting scoreboard: per-register pipeline position, bypass accept mask and writer slot.
// Latency: reads are combinational from state; writes visible one edge later.
// Backpressure: holds all state while shift_en is low; flash clears everything.
module score_board_n
  import issue_unit_n_pkg::*;
#(
  parameter int STAGES      = 3,
  parameter int NREG        = 32,
  parameter int WRITE_PORTS = 2,
  parameter int READ_PORTS  = 4
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          flash,
  input  logic                                          shift_en,
  input  logic [WRITE_PORTS-1:0]                        wr_vld,
  input  logic [WRITE_PORTS-1:0][REG_ADDR-1:0]          wr_addr,
  input  logic [WRITE_PORTS-1:0][STAGES-1:0]            wr_mask,
  input  logic [READ_PORTS-1:0][REG_ADDR-1:0]           rd_addr,
  output logic [READ_PORTS-1:0][2*STAGES+LINE_W-1:0]    rd_dat
);

  localparam logic [STAGES-1:0] POS_MSB = STAGES'(1) << (STAGES - 1);

  logic [NREG-1:0][STAGES-1:0] pos_q,  pos_d;
  logic [NREG-1:0][STAGES-1:0] mask_q, mask_d;
  logic [NREG-1:0][LINE_W-1:0] line_q, line_d;

  // next state: age every entry, then apply writes in slot order so the youngest writer wins
  always_comb begin
    pos_d  = pos_q;
    mask_d = mask_q;
    line_d = line_q;
    if (shift_en) begin
      for (int r = 0; r < NREG; r++) begin
        pos_d[r] = pos_q[r] >> 1;
      end
      for (int w = 0; w < WRITE_PORTS; w++) begin
        if (wr_vld[w] && (wr_addr[w] != '0) && (int'(wr_addr[w]) < NREG)) begin
          pos_d[wr_addr[w]]  = POS_MSB;
          mask_d[wr_addr[w]] = wr_mask[w];
          line_d[wr_addr[w]] = LINE_W'(w);
        end
      end
    end
  end

  // state register; flash wipes the board so every register reads from the regfile again
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q  <= '0;
      mask_q <= '0;
      line_q <= '0;
    end else if (flash) begin
      pos_q  <= '0;
      mask_q <= '0;
      line_q <= '0;
    end else begin
      pos_q  <= pos_d;
      mask_q <= mask_d;
      line_q <= line_d;
    end
  end

  // read ports; r0 is hardwired to "in regfile"
  always_comb begin
    for (int p = 0; p < READ_PORTS; p++) begin
      if (rd_addr[p] == '0) begin
        rd_dat[p] = '0;
      end else begin
        rd_dat[p] = {line_q[rd_addr[p]], mask_q[rd_addr[p]], pos_q[rd_addr[p]]};
      end
    end
  end

endmodule

// File: rtl/issue_unit_n.sv
// N-wide in-order issue: resolves operands, issues the longest ready prefix, registers FU packets.
// Latency: one cycle from queue head to fu_require/fu_valid.
// Backpressure: stall holds outputs and scoreboard with no pop; flash clears and also pops nothing.
module issue_unit_n
  import issue_unit_n_pkg::*;
#(
  parameter int ISSUE_WIDTH = 2,
  parameter int STAGES      = 3,
  parameter int NREG        = 32
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            flash,
  input  logic                                            stall,
  input  iq_elem_t [ISSUE_WIDTH-1:0]                      issue_require,
  input  logic [$clog2(ISSUE_WIDTH+1)-1:0]                iq_size,
  output logic [$clog2(ISSUE_WIDTH+1)-1:0]                iq_pop_number,
  output logic [2*ISSUE_WIDTH-1:0][2*STAGES+LINE_W-1:0]   sb_data,
  input  logic [2*ISSUE_WIDTH-1:0][REG_WIDTH-1:0]         bypass_result,
  output logic [2*ISSUE_WIDTH-1:0][REG_ADDR-1:0]          regfile_read_addr,
  input  logic [2*ISSUE_WIDTH-1:0][REG_WIDTH-1:0]         regfile_read_data,
  output fu_req_t [ISSUE_WIDTH-1:0]                       fu_require,
  output logic [ISSUE_WIDTH-1:0]                          fu_valid
);

  localparam int CW   = $clog2(ISSUE_WIDTH + 1);
  localparam int NOPS = 2 * ISSUE_WIDTH;
  localparam int SBW  = sb_entry_n(STAGES);

  logic                                 adv;
  logic [NOPS-1:0][SBW-1:0]             sb_rd;
  logic [NOPS-1:0]                      op_rdy;
  logic [NOPS-1:0][REG_WIDTH-1:0]       op_dat;
  logic [ISSUE_WIDTH-1:0]               slot_ok;
  logic [ISSUE_WIDTH-1:0]               prefix_ok;
  logic [ISSUE_WIDTH-1:0]               cand;
  logic [ISSUE_WIDTH-1:0]               issue_vld;
  logic [CW-1:0]                        issue_cnt;
  fu_req_t [ISSUE_WIDTH-1:0]            pkt;
  logic [ISSUE_WIDTH-1:0]               wr_vld;
  logic [ISSUE_WIDTH-1:0][REG_ADDR-1:0] wr_addr;
  logic [ISSUE_WIDTH-1:0][STAGES-1:0]   wr_mask;
  logic                                 unused_mask_hi;

  assign adv     = !stall && !flash;
  assign sb_data = sb_rd;

  // operand j of slot k is read through port 2k+j for both regfile and scoreboard
  always_comb begin
    regfile_read_addr = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      for (int j = 0; j < 2; j++) begin
        regfile_read_addr[2*k+j] = issue_require[k].src_addr[j];
      end
    end
  end

  // operand resolution: immediate, in-group hazard, regfile, bypass, else wait
  always_comb begin
    logic [REG_ADDR-1:0] a;
    logic [STAGES-1:0]   p;
    logic [STAGES-1:0]   m;
    logic                haz;
    op_rdy = '0;
    op_dat = '0;
    a      = '0;
    p      = '0;
    m      = '0;
    haz    = 1'b0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      for (int j = 0; j < 2; j++) begin
        a   = issue_require[k].src_addr[j];
        p   = sb_rd[2*k+j][STAGES-1:0];
        m   = sb_rd[2*k+j][2*STAGES-1:STAGES];
        haz = 1'b0;
        for (int i = 0; i < k; i++) begin
          if (issue_require[i].write_reg_need && (issue_require[i].write_reg_addr == a)) begin
            haz = 1'b1;
          end
        end
        if (!issue_require[k].need[j]) begin
          op_rdy[2*k+j] = 1'b1;
          op_dat[2*k+j] = issue_require[k].imm;
        end else if (haz) begin
          op_rdy[2*k+j] = 1'b0;
        end else if (p == '0) begin
          op_rdy[2*k+j] = 1'b1;
          op_dat[2*k+j] = regfile_read_data[2*k+j];
        end else if ((p & m) != '0) begin
          op_rdy[2*k+j] = 1'b1;
          op_dat[2*k+j] = bypass_result[2*k+j];
        end
      end
    end
  end

  // prefix selection; a branch needs its delay slot in the same group, so walk top-down first
  always_comb begin
    slot_ok   = '0;
    prefix_ok = '0;
    cand      = '0;
    issue_vld = '0;
    issue_cnt = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      slot_ok[k] = (k < int'(iq_size)) && op_rdy[2*k] && op_rdy[2*k+1];
    end
    prefix_ok[0] = slot_ok[0];
    for (int k = 1; k < ISSUE_WIDTH; k++) begin
      prefix_ok[k] = prefix_ok[k-1] && slot_ok[k];
    end
    cand[ISSUE_WIDTH-1] = prefix_ok[ISSUE_WIDTH-1] &&
                          (issue_require[ISSUE_WIDTH-1].exe_type != EXE_BRUNCH);
    for (int k = ISSUE_WIDTH - 2; k >= 0; k--) begin
      cand[k] = prefix_ok[k] && ((issue_require[k].exe_type != EXE_BRUNCH) || cand[k+1]);
    end
    issue_vld[0] = cand[0];
    for (int k = 1; k < ISSUE_WIDTH; k++) begin
      issue_vld[k] = issue_vld[k-1] && cand[k];
    end
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      issue_cnt = issue_cnt + CW'(issue_vld[k]);
    end
  end

  assign iq_pop_number = adv ? issue_cnt : '0;

  // FU packets and scoreboard write requests for each slot
  always_comb begin
    pkt     = '0;
    wr_vld  = '0;
    wr_addr = '0;
    wr_mask = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      pkt[k].exe_type       = issue_require[k].exe_type;
      pkt[k].opcode         = issue_require[k].opcode;
      pkt[k].src_val[0]     = op_dat[2*k];
      pkt[k].src_val[1]     = op_dat[2*k+1];
      pkt[k].write_reg_need = issue_require[k].write_reg_need;
      pkt[k].write_reg_addr = issue_require[k].write_reg_addr;
      wr_vld[k]  = issue_vld[k] && issue_require[k].write_reg_need;
      wr_addr[k] = issue_require[k].write_reg_addr;
      wr_mask[k] = issue_require[k].accept_mask[STAGES-1:0];
    end
  end

  // accept_mask bits above STAGES carry no meaning for this configuration
  always_comb begin
    unused_mask_hi = 1'b0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      unused_mask_hi = unused_mask_hi ^ (^(issue_require[k].accept_mask >> STAGES));
    end
  end

  score_board_n #(
    .STAGES      (STAGES),
    .NREG        (NREG),
    .WRITE_PORTS (ISSUE_WIDTH),
    .READ_PORTS  (NOPS)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .flash    (flash),
    .shift_en (adv),
    .wr_vld   (wr_vld),
    .wr_addr  (wr_addr),
    .wr_mask  (wr_mask),
    .rd_addr  (regfile_read_addr),
    .rd_dat   (sb_rd)
  );

  // output register: load issued packets, nop elsewhere; hold on stall, clear on flash
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fu_require <= '0;
      fu_valid   <= '0;
    end else if (flash) begin
      fu_require <= '0;
      fu_valid   <= '0;
    end else if (!stall) begin
      for (int k = 0; k < ISSUE_WIDTH; k++) begin
        fu_valid[k]   <= issue_vld[k];
        fu_require[k] <= issue_vld[k] ? pkt[k] : FU_NOP;
      end
    end
  end

endmodule

// File: doc/issue_unit_n.md
# issue_unit_n

Parametrised N-wide in-order issue stage with an integrated shifting scoreboard. It sits between the issue queue and the execute functional units. Each cycle it issues the longest ready in-order prefix of the queue head, up to ISSUE_WIDTH instructions. Operands come from the immediate field, the regfile, or the bypass network. Issued instructions are held in a registered FU_REQUIRE output. It extends the dual-issue stage to any width and any pipeline depth, and adds registered outputs, scoreboard ageing, and write-after-write (WAW) arbitration.

## Interface

Parameters:
- ISSUE_WIDTH, 2, slots examined and issued per cycle (1..4)
- STAGES, 3, execute stages tracked by the scoreboard position vector
- NREG, 32, architectural registers

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flash  in  1  pipeline flush
- stall  in  1  downstream stall
- issue_require  in  ISSUE_WIDTH×ISSUE_QUEUE_ELEMENT  queue head; slot 0 is oldest
- iq_size  in  $clog2(ISSUE_WIDTH+1)  valid entries at the head
- iq_pop_number  out  $clog2(ISSUE_WIDTH+1)  entries consumed this cycle
- sb_data  out  2·ISSUE_WIDTH×SB_ENTRY_N  scoreboard view per source operand, for bypass selection
- bypass_result  in  2·ISSUE_WIDTH×REG_WIDTH  bypass value per source operand
- regfile_read_addr  out  2·ISSUE_WIDTH×REG_ADDR  operand j of slot k is at index 2k+j
- regfile_read_data  in  2·ISSUE_WIDTH×REG_WIDTH  regfile data
- fu_require  out  ISSUE_WIDTH×FU_REQUIRE  registered issued packets
- fu_valid  out  ISSUE_WIDTH  per-slot valid for fu_require

## Operation

Scoreboard entry per register: position[STAGES-1:0] (one-hot or zero), accept_mask[STAGES-1:0], line.
- Zero position means the value is in the regfile.

Operand resolution (slot k, operand j), evaluated in order:
1. need==0: ready, value is the immediate.
2. An older slot i<k in the same group has write_reg_need and write_reg_addr == the operand address: not ready. In-group forwarding is not supported.
3. position==0: ready, value is regfile_read_data.
4. (position & accept_mask) != 0: ready, value is bypass_result.
5. Otherwise: not ready.

Issue selection:
- Slot k issues only if all of the following hold:
  - k < iq_size
  - every slot below k issues
  - both of slot k's operands are ready
- A branch (exe_type==brunch) in slot k issues only if slot k+1 also issues, because the delay slot must issue in the same group.
  - A branch in slot ISSUE_WIDTH-1 never issues, and the issue count stops before it.
- iq_pop_number = number of issued slots when neither stall nor flash is asserted; otherwise 0.

Scoreboard update on each cycle with no stall and no flash:
- Every entry shifts: position >>= 1.
- Every issued slot with write_reg_need writes its entry: position = 1<<(STAGES-1), accept_mask from the queue element, line = slot index.
- A write overrides the shift of that same register.
- WAW in one group: the highest-numbered slot wins.
- Register 0 is never written and always reads position 0.

Output register:
- fu_require[k] and fu_valid[k] are loaded from slot k. Slots that do not issue load nop (all zero) with valid=0.

Stall:
- fu_require, fu_valid and the scoreboard hold their values.
- No pop.

Flash (priority over stall):
- Scoreboard cleared to all zero.
- fu_valid cleared to 0 and fu_require to nop on the next edge.
- No pop.

## Timing

- Reset (async assert on rst_n low): fu_require = nop, fu_valid = 0, all scoreboard entries zero.
  - iq_pop_number is combinational and reads 0 when iq_size is 0.
- Issue decision, iq_pop_number, regfile_read_addr and sb_data are combinational in cycle t.
- fu_require and fu_valid are valid from cycle t+1.
- A destination issued in t is seen by reads at t+1 with position = MSB. It reaches position 0 after STAGES non-stall edges.
- Latency from queue to FU is one cycle. Sustained throughput is ISSUE_WIDTH per cycle when there are no hazards.

## Structure

- The shared package (defines.svh) holds:
  - SB_ENTRY_N, parametrised on STAGES
  - issue/FU struct extensions
  - the nop constant
- Sub-module score_board_n(STAGES, NREG, WRITE_PORTS=ISSUE_WIDTH, READ_PORTS=2·ISSUE_WIDTH) contains the shift, write arbitration and flash clear.
- issue_unit_n contains operand resolution, prefix selection and the output register.

## Test plan

- ISSUE_WIDTH=4, iq_size=4, four independent ALU ops on r1..r4, clean scoreboard -> pop=4; next cycle fu_valid=4'b1111; r1..r4 position 3'b100.
- Slot 0 writes r5, slot 1 reads r5 -> pop=1. Next cycle, r5 position=100 and accept_mask=100, so slot 1 reads from bypass -> pop≥1.
- Branch in slot 0, delay slot not ready -> pop=0. Branch in slot 3 with slots 0..2 ready -> pop=3.
- Slots 0 and 2 both write r7 -> r7 line=2. After 3 non-stall cycles r7 position=000, and its reader takes regfile data.
- Entry at position 010, stall for 5 cycles -> position stays 010 and fu_require is held. Flash during the stall -> fu_valid=0, all positions 000.
- rst_n pulled low mid-stream, asynchronous to clk -> fu_valid=0 immediately and the scoreboard clears.
